// File: rtl/im_fetch_sequencer_if.sv
// Handshake bundle for the two low-dimensional item-memory address ports (A and B).
// The sequencer drives the master side; the item memory is the slave.
interface im_fetch_sequencer_if #(
  parameter int ImAddrWidth = 32
) ();
  logic [ImAddrWidth-1:0] lowdim_a_data;
  logic                   im_a_data_valid;
  logic                   im_a_data_ready;
  logic [ImAddrWidth-1:0] lowdim_b_data;
  logic                   im_b_data_valid;
  logic                   im_b_data_ready;

  modport master (
    output lowdim_a_data, im_a_data_valid,
    input  im_a_data_ready,
    output lowdim_b_data, im_b_data_valid,
    input  im_b_data_ready
  );

  modport slave (
    input  lowdim_a_data, im_a_data_valid,
    output im_a_data_ready,
    input  lowdim_b_data, im_b_data_valid,
    output im_b_data_ready
  );
endinterface

// File: rtl/im_fetch_sequencer.sv
// Strided address sequencer (base + i*stride, i = 0..N-1) for item-memory ports A and B.
// Define IM_FETCH_SEQ_PERF_EN to add the saturating stall_cycles_o counter.
module im_fetch_sequencer #(
  parameter int ImAddrWidth = 32,
  parameter int CountWidth  = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clr_i,
  input  logic                   start_i,
  input  logic [CountWidth-1:0]  cfg_num_items_i,
  input  logic [ImAddrWidth-1:0] cfg_base_a_i,
  input  logic [ImAddrWidth-1:0] cfg_stride_a_i,
  input  logic [ImAddrWidth-1:0] cfg_base_b_i,
  input  logic [ImAddrWidth-1:0] cfg_stride_b_i,
  input  logic                   cfg_port_b_en_i,
  output logic                   busy_o,
  output logic                   done_o,
`ifdef IM_FETCH_SEQ_PERF_EN
  output logic [31:0]            stall_cycles_o,
`endif
  im_fetch_sequencer_if.master   mem
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                 state_r;
  state_e                 state_nxt_s;
  logic [CountWidth-1:0]  num_r;
  logic [CountWidth-1:0]  cnt_a_r;
  logic [CountWidth-1:0]  cnt_b_r;
  logic [CountWidth-1:0]  cnt_a_nxt_s;
  logic [CountWidth-1:0]  cnt_b_nxt_s;
  logic [ImAddrWidth-1:0] addr_a_r;
  logic [ImAddrWidth-1:0] addr_b_r;
  logic [ImAddrWidth-1:0] addr_a_nxt_s;
  logic [ImAddrWidth-1:0] addr_b_nxt_s;
  logic [ImAddrWidth-1:0] stride_a_r;
  logic [ImAddrWidth-1:0] stride_b_r;
  logic                   b_en_r;
  logic                   valid_a_r;
  logic                   valid_b_r;
  logic                   busy_r;
  logic                   done_r;
  logic                   hs_a_s;
  logic                   hs_b_s;
  logic                   start_ok_s;
  logic                   run_end_s;
  logic                   n_zero_s;

  assign hs_a_s     = valid_a_r & mem.im_a_data_ready;
  assign hs_b_s     = valid_b_r & mem.im_b_data_ready;
  assign start_ok_s = (state_r == IDLE) & start_i & ~clr_i;
  assign n_zero_s   = (cfg_num_items_i == {CountWidth{1'b0}});

  // Next counter/address values and FSM next state.
  always_comb begin
    cnt_a_nxt_s  = cnt_a_r;
    cnt_b_nxt_s  = cnt_b_r;
    addr_a_nxt_s = addr_a_r;
    addr_b_nxt_s = addr_b_r;
    state_nxt_s  = state_r;
    run_end_s    = 1'b0;

    if (hs_a_s) begin
      cnt_a_nxt_s  = cnt_a_r + CountWidth'(1'b1);
      addr_a_nxt_s = addr_a_r + stride_a_r;
    end else begin
      cnt_a_nxt_s  = cnt_a_r;
      addr_a_nxt_s = addr_a_r;
    end

    if (hs_b_s) begin
      cnt_b_nxt_s  = cnt_b_r + CountWidth'(1'b1);
      addr_b_nxt_s = addr_b_r + stride_b_r;
    end else begin
      cnt_b_nxt_s  = cnt_b_r;
      addr_b_nxt_s = addr_b_r;
    end

    // A disabled port B is treated as already complete.
    run_end_s = (cnt_a_nxt_s == num_r) & (~b_en_r | (cnt_b_nxt_s == num_r));

    if (clr_i) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_i) begin
            state_nxt_s = n_zero_s ? DONE : RUN;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        RUN: begin
          if (run_end_s) begin
            state_nxt_s = DONE;
          end else begin
            state_nxt_s = RUN;
          end
        end
        DONE:    state_nxt_s = IDLE;
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // FSM state register plus registered status outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s == RUN);
      done_r  <= (state_nxt_s == DONE);
    end
  end

  // Latched configuration, issue counters, address registers and valids.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      num_r      <= {CountWidth{1'b0}};
      stride_a_r <= {ImAddrWidth{1'b0}};
      stride_b_r <= {ImAddrWidth{1'b0}};
      b_en_r     <= 1'b0;
      cnt_a_r    <= {CountWidth{1'b0}};
      cnt_b_r    <= {CountWidth{1'b0}};
      addr_a_r   <= {ImAddrWidth{1'b0}};
      addr_b_r   <= {ImAddrWidth{1'b0}};
      valid_a_r  <= 1'b0;
      valid_b_r  <= 1'b0;
    end else if (clr_i) begin
      cnt_a_r    <= {CountWidth{1'b0}};
      cnt_b_r    <= {CountWidth{1'b0}};
      addr_a_r   <= {ImAddrWidth{1'b0}};
      addr_b_r   <= {ImAddrWidth{1'b0}};
      valid_a_r  <= 1'b0;
      valid_b_r  <= 1'b0;
    end else if (start_ok_s) begin
      num_r      <= cfg_num_items_i;
      stride_a_r <= cfg_stride_a_i;
      stride_b_r <= cfg_stride_b_i;
      b_en_r     <= cfg_port_b_en_i;
      cnt_a_r    <= {CountWidth{1'b0}};
      cnt_b_r    <= {CountWidth{1'b0}};
      addr_a_r   <= cfg_base_a_i;
      addr_b_r   <= cfg_base_b_i;
      valid_a_r  <= ~n_zero_s;
      valid_b_r  <= ~n_zero_s & cfg_port_b_en_i;
    end else if (state_r == RUN) begin
      cnt_a_r    <= cnt_a_nxt_s;
      cnt_b_r    <= cnt_b_nxt_s;
      addr_a_r   <= addr_a_nxt_s;
      addr_b_r   <= addr_b_nxt_s;
      // Counters never pass num_r, so inequality means "items left".
      valid_a_r  <= (cnt_a_nxt_s != num_r);
      valid_b_r  <= b_en_r & (cnt_b_nxt_s != num_r);
    end else begin
      valid_a_r  <= 1'b0;
      valid_b_r  <= 1'b0;
    end
  end

`ifdef IM_FETCH_SEQ_PERF_EN
  logic [31:0] stall_r;
  logic        stall_s;

  assign stall_s = (valid_a_r & ~mem.im_a_data_ready) | (valid_b_r & ~mem.im_b_data_ready);

  // Saturating count of RUN cycles in which an offered address was not taken.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_r <= 32'd0;
    end else if (clr_i | start_ok_s) begin
      stall_r <= 32'd0;
    end else if ((state_r == RUN) && stall_s && (stall_r != 32'hFFFF_FFFF)) begin
      stall_r <= stall_r + 32'd1;
    end else begin
      stall_r <= stall_r;
    end
  end

  assign stall_cycles_o = stall_r;
`endif

  assign busy_o              = busy_r;
  assign done_o              = done_r;
  assign mem.lowdim_a_data   = addr_a_r;
  assign mem.im_a_data_valid = valid_a_r;
  assign mem.lowdim_b_data   = addr_b_r;
  assign mem.im_b_data_valid = valid_b_r;

endmodule
